// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave bridging PS register accesses onto the TLK2711 register bus.
// One transaction in flight; reads and writes become single-cycle bus strobes.
module tlk2711_axil_reg_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned ADDR_LSB       = 3,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      ps_clk,
    input  logic                      ps_rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [63:0]               s_axil_wdata,
    input  logic [7:0]                s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [63:0]               s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic                      o_reg_wen,
    output logic [15:0]               o_reg_waddr,
    output logic [63:0]               o_reg_wdata,
    output logic                      o_reg_ren,
    output logic [15:0]               o_reg_raddr,
    input  logic [63:0]               i_reg_rdata
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned REG_AW = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                active_q;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic [REG_AW-1:0]   aw_word_q, aw_word_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                last_wr_q, last_wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [REG_AW-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ren_q, ren_d;
    logic [REG_AW-1:0]   raddr_q, raddr_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                idle;
    logic                rd_eligible;
    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic [REG_AW-1:0]   aw_word_in;
    logic [REG_AW-1:0]   ar_word_in;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

    assign aw_word_in = s_axil_awaddr[ADDR_LSB +: REG_AW];
    assign ar_word_in = s_axil_araddr[ADDR_LSB +: REG_AW];

    // Arbitration: a read may go only when no write is half-captured, and it
    // yields to a pending write unless the previous transaction was a write.
    assign idle        = (state_q == IDLE) && active_q;
    assign rd_eligible = !aw_held_q && !w_held_q &&
                         (last_wr_q || (!s_axil_awvalid && !s_axil_wvalid));

    assign s_axil_arready = idle && rd_eligible;
    assign s_axil_awready = idle && !aw_held_q && !(rd_eligible && s_axil_arvalid);
    assign s_axil_wready  = idle && !w_held_q  && !(rd_eligible && s_axil_arvalid);

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid  && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = RESP_OKAY;
    assign o_reg_wen     = wen_q;
    assign o_reg_waddr   = waddr_q;
    assign o_reg_wdata   = wdata_q;
    assign o_reg_ren     = ren_q;
    assign o_reg_raddr   = raddr_q;

    // State and registered outputs
    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            state_q   <= IDLE;
            active_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_word_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ren_q     <= 1'b0;
            raddr_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_word_q <= aw_word_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ren_q     <= ren_d;
            raddr_q   <= raddr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_word_d = aw_word_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        ren_d     = 1'b0;
        raddr_d   = raddr_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_word_d = aw_word_in;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axil_wdata;
                    w_strb_d = s_axil_wstrb;
                end
                // Strobe is launched on the edge that completes the write capture
                if (aw_held_d && w_held_d) begin
                    state_d = WR_ISSUE;
                    if (w_strb_d == {STRB_W{1'b1}}) begin
                        wen_d   = 1'b1;
                        waddr_d = aw_word_d;
                        wdata_d = w_data_d;
                    end
                end else if (ar_hs) begin
                    state_d = RD_ISSUE;
                    ren_d   = 1'b1;
                    raddr_d = ar_word_in;
                end
            end
            WR_ISSUE: begin
                bvalid_d = 1'b1;
                bresp_d  = (w_strb_q == {STRB_W{1'b1}}) ? RESP_OKAY : RESP_SLVERR;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    last_wr_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_ISSUE: begin
                cnt_d   = CNT_W'(RD_LATENCY);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    rdata_d  = i_reg_rdata;
                    rvalid_d = 1'b1;
                    state_d  = RD_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    rvalid_d  = 1'b0;
                    last_wr_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Scoreboard bench for tlk2711_axil_reg_bridge: directed cases plus random
// traffic against a register-file model; a second instance covers RD_LATENCY=4.
module tb_tlk2711_axil_reg_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A (RD_LATENCY = 1)
    logic [31:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata, reg_wdata, reg_rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        reg_wen, reg_ren;
    logic [15:0] reg_waddr, reg_raddr;

    // Instance B (RD_LATENCY = 4), read-only traffic
    logic [31:0] awaddr_b, araddr_b;
    logic        awvalid_b, awready_b, wvalid_b, wready_b, bvalid_b, bready_b;
    logic        arvalid_b, arready_b, rvalid_b, rready_b;
    logic [63:0] wdata_b, rdata_b, reg_wdata_b, reg_rdata_b;
    logic [7:0]  wstrb_b;
    logic [1:0]  bresp_b, rresp_b;
    logic        reg_wen_b, reg_ren_b;
    logic [15:0] reg_waddr_b, reg_raddr_b;

    tlk2711_axil_reg_bridge #(.AXI_ADDR_WIDTH(32), .ADDR_LSB(3), .RD_LATENCY(1)) dut (
        .ps_clk(clk), .ps_rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .o_reg_wen(reg_wen), .o_reg_waddr(reg_waddr), .o_reg_wdata(reg_wdata),
        .o_reg_ren(reg_ren), .o_reg_raddr(reg_raddr), .i_reg_rdata(reg_rdata)
    );

    tlk2711_axil_reg_bridge #(.AXI_ADDR_WIDTH(32), .ADDR_LSB(3), .RD_LATENCY(4)) dut_b (
        .ps_clk(clk), .ps_rst_n(rst_n),
        .s_axil_awaddr(awaddr_b), .s_axil_awvalid(awvalid_b), .s_axil_awready(awready_b),
        .s_axil_wdata(wdata_b), .s_axil_wstrb(wstrb_b), .s_axil_wvalid(wvalid_b), .s_axil_wready(wready_b),
        .s_axil_bresp(bresp_b), .s_axil_bvalid(bvalid_b), .s_axil_bready(bready_b),
        .s_axil_araddr(araddr_b), .s_axil_arvalid(arvalid_b), .s_axil_arready(arready_b),
        .s_axil_rdata(rdata_b), .s_axil_rresp(rresp_b), .s_axil_rvalid(rvalid_b), .s_axil_rready(rready_b),
        .o_reg_wen(reg_wen_b), .o_reg_waddr(reg_waddr_b), .o_reg_wdata(reg_wdata_b),
        .o_reg_ren(reg_ren_b), .o_reg_raddr(reg_raddr_b), .i_reg_rdata(reg_rdata_b)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t         exp_wen[$];
    logic [15:0] exp_ren[$];
    logic [1:0]  exp_b[$];
    logic [63:0] exp_r[$];

    logic [63:0] ref_mem [logic [15:0]];
    logic [63:0] dev_mem [logic [15:0]];
    int          wen_cnt = 0;
    int          last_wen_cyc = -1;
    int          last_ren_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] dflt(input logic [15:0] a);
        return {a, ~a, a ^ 16'hA5C3, 16'h2711};
    endfunction

    function automatic logic [63:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] dev_rd(input logic [15:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    // Register-file device on bus A: data valid only in the cycle RD_LATENCY after ren
    initial begin
        int          dly;
        logic [15:0] pa;
        dly = 0;
        pa  = '0;
        reg_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dly > 0) begin
                dly = dly - 1;
                reg_rdata = (dly == 0) ? dev_rd(pa) : {$urandom, $urandom};
            end else begin
                reg_rdata = {$urandom, $urandom};
            end
            if (reg_ren) begin
                dly = 1;
                pa  = reg_raddr;
            end
            if (reg_wen) dev_mem[reg_waddr] = reg_wdata;
        end
    end

    // Device on bus B, four-cycle read latency, never written
    initial begin
        int          dly;
        logic [15:0] pa;
        dly = 0;
        pa  = '0;
        reg_rdata_b = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dly > 0) begin
                dly = dly - 1;
                reg_rdata_b = (dly == 0) ? dflt(pa) : {$urandom, $urandom};
            end else begin
                reg_rdata_b = {$urandom, $urandom};
            end
            if (reg_ren_b) begin
                dly = 4;
                pa  = reg_raddr_b;
            end
        end
    end

    // Monitor: pops expected responses whenever instance A presents one
    initial begin
        logic prev_wen;
        prev_wen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (reg_wen) begin
                    chk("wen_single_cycle", 64'(prev_wen), 64'd0);
                    chk("wen_expected", 64'(exp_wen.size() != 0), 64'd1);
                    if (exp_wen.size() != 0) begin
                        wr_t e;
                        e = exp_wen.pop_front();
                        chk("wen_waddr", 64'(reg_waddr), 64'(e.a));
                        chk("wen_wdata", reg_wdata, e.d);
                    end
                    wen_cnt++;
                    last_wen_cyc = cyc;
                end
                if (reg_ren) begin
                    chk("ren_expected", 64'(exp_ren.size() != 0), 64'd1);
                    if (exp_ren.size() != 0) chk("ren_raddr", 64'(reg_raddr), 64'(exp_ren.pop_front()));
                    last_ren_cyc = cyc;
                end
                if (bvalid && bready) begin
                    chk("b_expected", 64'(exp_b.size() != 0), 64'd1);
                    if (exp_b.size() != 0) chk("bresp", 64'(bresp), 64'(exp_b.pop_front()));
                end
                if (rvalid && rready) begin
                    chk("r_expected", 64'(exp_r.size() != 0), 64'd1);
                    if (exp_r.size() != 0) chk("rdata", rdata, exp_r.pop_front());
                    chk("rresp", 64'(rresp), 64'd0);
                end
            end
            prev_wen = reg_wen && rst_n;
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int daw, input int dw, input int bdly, output int t_hs);
        int   t_aw, t_w, t_b, wen_before;
        logic full, got_aw, got_w, got_b;
        full = (strb == 8'hFF);
        if (full) begin
            exp_wen.push_back({addr[18:3], data});
            ref_mem[addr[18:3]] = data;
        end
        exp_b.push_back(full ? 2'b00 : 2'b10);
        wen_before = wen_cnt;
        t_aw = 0; t_w = 0; t_b = 0;
        got_aw = 0; got_w = 0; got_b = 0;
        fork
            begin
                repeat (daw) begin @(posedge clk); #1; end
                awaddr = addr; awvalid = 1'b1;
                for (int i = 0; i < 200 && !got_aw; i++) begin
                    @(negedge clk);
                    if (awready) begin got_aw = 1; t_aw = cyc; end
                end
                @(posedge clk); #1;
                awvalid = 1'b0;
            end
            begin
                repeat (dw) begin @(posedge clk); #1; end
                wdata = data; wstrb = strb; wvalid = 1'b1;
                for (int i = 0; i < 200 && !got_w; i++) begin
                    @(negedge clk);
                    if (wready) begin got_w = 1; t_w = cyc; end
                end
                @(posedge clk); #1;
                wvalid = 1'b0;
            end
        join
        chk("aw_handshake", 64'(got_aw), 64'd1);
        chk("w_handshake", 64'(got_w), 64'd1);
        t_hs = (t_aw > t_w) ? t_aw : t_w;
        for (int i = 0; i < 50 && !got_b; i++) begin
            @(negedge clk);
            if (bvalid) begin got_b = 1; t_b = cyc; end
        end
        chk("b_arrived", 64'(got_b), 64'd1);
        chk("b_latency", 64'(t_b), 64'(t_hs + 2));
        for (int k = 0; k < bdly; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("b_hold", 64'(bvalid), 64'd1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 1'b0;
        chk("wen_count", 64'(wen_cnt), 64'(wen_before + (full ? 1 : 0)));
        if (full) chk("wen_latency", 64'(last_wen_cyc), 64'(t_hs + 1));
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdly, output int t_ar);
        int          t_r;
        logic        got_ar, got_r;
        logic [63:0] e;
        e = ref_rd(addr[18:3]);
        exp_ren.push_back(addr[18:3]);
        exp_r.push_back(e);
        t_ar = 0; t_r = 0; got_ar = 0; got_r = 0;
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 200 && !got_ar; i++) begin
            @(negedge clk);
            if (arready) begin got_ar = 1; t_ar = cyc; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("ar_handshake", 64'(got_ar), 64'd1);
        for (int i = 0; i < 50 && !got_r; i++) begin
            @(negedge clk);
            if (rvalid) begin got_r = 1; t_r = cyc; end
        end
        chk("r_arrived", 64'(got_r), 64'd1);
        chk("r_latency", 64'(t_r), 64'(t_ar + 3));
        chk("ren_latency", 64'(last_ren_cyc), 64'(t_ar + 1));
        for (int k = 0; k < rdly; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("r_hold_valid", 64'(rvalid), 64'd1);
            chk("r_hold_data", rdata, e);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // Read whose response is killed by a reset pulse while the data is pending
    task automatic do_read_abort(input logic [31:0] addr);
        logic got_ar;
        got_ar = 0;
        exp_ren.push_back(addr[18:3]);
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 200 && !got_ar; i++) begin
            @(negedge clk);
            if (arready) got_ar = 1;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("abort_ar_handshake", 64'(got_ar), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_rvalid_in_reset", 64'(rvalid), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rvalid", 64'(rvalid), 64'd0);
        end
        chk("abort_arready_back", 64'(arready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read_b(input logic [31:0] addr);
        int   t_ar, t_r;
        logic got_ar, got_r;
        t_ar = 0; t_r = 0; got_ar = 0; got_r = 0;
        araddr_b = addr; arvalid_b = 1'b1;
        for (int i = 0; i < 200 && !got_ar; i++) begin
            @(negedge clk);
            if (arready_b) begin got_ar = 1; t_ar = cyc; end
        end
        @(posedge clk); #1;
        arvalid_b = 1'b0;
        chk("b4_ar_handshake", 64'(got_ar), 64'd1);
        for (int i = 0; i < 50 && !got_r; i++) begin
            @(negedge clk);
            if (rvalid_b) begin got_r = 1; t_r = cyc; end
        end
        chk("b4_r_latency", 64'(t_r), 64'(t_ar + 6));
        chk("b4_rdata", rdata_b, dflt(addr[18:3]));
        chk("b4_raddr", 64'(reg_raddr_b), 64'(addr[18:3]));
        @(posedge clk); #1;
        rready_b = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rready_b = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          tw, tr, t;
        logic [31:0] a;
        logic [15:0] w;
        logic [7:0]  s;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        awaddr_b = '0; awvalid_b = 0; wdata_b = '0; wstrb_b = '0; wvalid_b = 0; bready_b = 0;
        araddr_b = '0; arvalid_b = 0; rready_b = 0;
        ref_mem[16'h0100] = 64'h0000_0000_DEAD_BEEF;
        dev_mem[16'h0100] = 64'h0000_0000_DEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", 64'({awready, wready, arready}), 64'd0);
        chk("rst_valids", 64'({bvalid, rvalid, reg_wen, reg_ren}), 64'd0);
        chk("rst_resps", 64'({bresp, rresp}), 64'd0);
        chk("rst_addrs", 64'({reg_waddr, reg_raddr}), 64'd0);
        chk("rst_wdata", reg_wdata, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous AW/W/AR out of reset: write first
        fork
            do_write(32'h0000_0040, 64'h1111_2222_3333_4444, 8'hFF, 0, 0, 1, tw);
            do_read(32'h0000_0200, 0, tr);
        join
        chk("contention1_write_first", 64'(tw < tr), 64'd1);

        do_write(32'h0000_0108, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0, t);

        // Last served was a write: read wins, and its data holds while rready is low
        fork
            do_write(32'h0000_01F0, 64'h5555_6666_7777_8888, 8'hFF, 0, 0, 0, tw);
            do_read(32'h0000_0800, 5, tr);
        join
        chk("contention2_read_first", 64'(tr < tw), 64'd1);

        do_write(32'h0000_02A8, 64'hBAD0_BAD0_BAD0_BAD0, 8'h0F, 3, 0, 2, t);
        do_write(32'h0000_02A8, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, 0, t);
        do_read(32'h0000_02A8, 1, tr);
        do_read(32'h0000_0108, 0, tr);

        do_read_abort(32'h0000_0808);
        do_read(32'h0000_0808, 2, tr);

        do_read_b(32'h0000_0010);
        do_read_b(32'hFFF8_0A38);
        do_read_b(32'h1234_5677);

        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom_range(0, 7)) + 16'h0040;
            a = {13'($urandom), w, 3'($urandom)};
            if ($urandom_range(0, 1) == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
                do_write(a, {$urandom, $urandom}, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), t);
            end else begin
                do_read(a, $urandom_range(0, 3), tr);
            end
        end

        repeat (3) @(posedge clk);
        chk("left_wen", 64'(exp_wen.size()), 64'd0);
        chk("left_ren", 64'(exp_ren.size()), 64'd0);
        chk("left_b", 64'(exp_b.size()), 64'd0);
        chk("left_r", 64'(exp_r.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
